// File: rtl/spi_responder_mem.sv
// SPI mode-0 responder with a small byte-addressed register memory.
// All SPI pins are oversampled in the system clock domain.
module spi_responder_mem #(
  parameter int unsigned ADDR_W    = 4,
  parameter logic [7:0]  CMD_WRITE = 8'h02,
  parameter logic [7:0]  CMD_READ  = 8'h03
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_spi_CE,
  input  logic              io_spi_MOSI,
  input  logic              io_spi_S_CLK,
  output logic              io_spi_MISO,
  output logic              io_wr_valid,
  output logic [ADDR_W-1:0] io_wr_addr,
  output logic [7:0]        io_wr_data,
  output logic              io_active
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_CMD        = 3'd1;
  localparam logic [2:0] ST_WRITE_ADDR = 3'd2;
  localparam logic [2:0] ST_READ_ADDR  = 3'd3;
  localparam logic [2:0] ST_WRITE_DATA = 3'd4;
  localparam logic [2:0] ST_READ_DATA  = 3'd5;
  localparam logic [2:0] ST_IGNORE     = 3'd6;

  logic              ce_s1, ce_s2, ce_d;
  logic              mosi_s1, mosi_s2;
  logic              sclk_s1, sclk_s2, sclk_d;
  logic [2:0]        state_q, state_d;
  logic [2:0]        bit_cnt_q;
  logic [6:0]        rx_q;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        mem [DEPTH];

  logic       ce_fall_c, ce_rise_c, rise_c, fall_c, byte_done_c;
  logic [7:0] rx_byte_c;
  logic       commit_c, addr_ld_c, addr_inc_c, frame_start_c;

  // SCLK edges only count while CE is low, so a CE rise in the same cycle masks them
  assign ce_fall_c   = ce_d & ~ce_s2;
  assign ce_rise_c   = ~ce_d & ce_s2;
  assign rise_c      = ~sclk_d & sclk_s2 & ~ce_s2;
  assign fall_c      = sclk_d & ~sclk_s2 & ~ce_s2;
  assign rx_byte_c   = {rx_q, mosi_s2};
  assign byte_done_c = rise_c && (bit_cnt_q == 3'd7) && (state_q != ST_IDLE);

  // Next-state and datapath control
  always_comb begin
    state_d       = state_q;
    tx_d          = tx_q;
    commit_c      = 1'b0;
    addr_ld_c     = 1'b0;
    addr_inc_c    = 1'b0;
    frame_start_c = 1'b0;
    if (ce_rise_c) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ce_fall_c) begin
            state_d       = ST_CMD;
            frame_start_c = 1'b1;
            tx_d          = 8'h00;
          end
        end
        ST_CMD: begin
          if (byte_done_c) begin
            if (rx_byte_c == CMD_WRITE)     state_d = ST_WRITE_ADDR;
            else if (rx_byte_c == CMD_READ) state_d = ST_READ_ADDR;
            else                            state_d = ST_IGNORE;
          end
        end
        ST_WRITE_ADDR: begin
          if (byte_done_c) begin
            addr_ld_c = 1'b1;
            state_d   = ST_WRITE_DATA;
          end
        end
        ST_READ_ADDR: begin
          if (byte_done_c) begin
            addr_ld_c = 1'b1;
            state_d   = ST_READ_DATA;
          end
        end
        ST_WRITE_DATA: begin
          if (byte_done_c) commit_c = 1'b1;
        end
        ST_READ_DATA: begin
          // Load on the byte-boundary fall so the MSB is ready before the next rise
          if (fall_c) begin
            if (bit_cnt_q == 3'd0) begin
              tx_d       = mem[addr_q];
              addr_inc_c = 1'b1;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ce_s1       <= 1'b0;
      ce_s2       <= 1'b0;
      ce_d        <= 1'b0;
      mosi_s1     <= 1'b0;
      mosi_s2     <= 1'b0;
      sclk_s1     <= 1'b0;
      sclk_s2     <= 1'b0;
      sclk_d      <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'h00;
      addr_q      <= '0;
      io_spi_MISO <= 1'b0;
      io_wr_valid <= 1'b0;
      io_wr_addr  <= '0;
      io_wr_data  <= 8'h00;
      io_active   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'h00;
    end else begin
      ce_s1   <= io_spi_CE;
      ce_s2   <= ce_s1;
      ce_d    <= ce_s2;
      mosi_s1 <= io_spi_MOSI;
      mosi_s2 <= mosi_s1;
      sclk_s1 <= io_spi_S_CLK;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      state_q <= state_d;
      tx_q    <= tx_d;

      if (frame_start_c)                       bit_cnt_q <= 3'd0;
      else if (rise_c && state_q != ST_IDLE)   bit_cnt_q <= bit_cnt_q + 3'd1;

      if (rise_c) rx_q <= rx_byte_c[6:0];

      if (addr_ld_c)                     addr_q <= rx_byte_c[ADDR_W-1:0];
      else if (addr_inc_c || commit_c)   addr_q <= addr_q + ADDR_W'(1);

      if (commit_c) begin
        mem[addr_q] <= rx_byte_c;
        io_wr_addr  <= addr_q;
        io_wr_data  <= rx_byte_c;
      end
      io_wr_valid <= commit_c;
      io_spi_MISO <= (state_d == ST_READ_DATA) ? tx_d[7] : 1'b0;
      io_active   <= (state_d != ST_IDLE);
    end
  end

endmodule
